// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: the operation
// encoding and its width.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_t;

endpackage

// File: rtl/logic_op_eval.sv
// Purely combinational bitwise evaluator. It sits between the operand stage
// and the result stage of logic_unit_pipe. NOT_A and PASS_A ignore b.
module logic_op_eval
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result
);

    // Select the bitwise function named by the op code.
    always_comb begin
        result = '0;
        case (op_t'(op))
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_NAND:   result = ~(a & b);
            OP_NOR:    result = ~(a | b);
            OP_XNOR:   result = ~(a ^ b);
            OP_NOT_A:  result = ~a;
            OP_PASS_A: result = a;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// S1 holds the accepted operands, S2 holds the evaluated result and its
// zero/all-ones flags. A stage may load whenever its downstream neighbour is
// empty or moving, so out_ready reaches in_ready combinationally and a full
// pipeline with out_ready high still accepts one op per cycle.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] done_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] eval_result;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    logic_op_eval #(
        .WIDTH (WIDTH)
    ) u_eval (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (eval_result)
    );

    // Operand stage: capture a new op whenever S1 is free or draining forward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    // Result stage: take the evaluated op from S1, holding data under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            ones     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result <= eval_result;
                zero   <= (eval_result == '0);
                ones   <= &eval_result;
            end
        end
    end

    // Count every consumed result, wrapping naturally at the counter width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_count <= '0;
        end else if (s2_valid && out_ready) begin
            done_count <= done_count + 1'b1;
        end
    end

endmodule
